// File: rtl/cmd_host_comm_if.sv
`default_nettype none
// ============================================================================
// Module   : cmd_host_comm_if
// Purpose  : Command/response handshake bundle between a host user and
//            cmd_host_comm (the link endpoint).
// Signals  : snd_cmd      - 1-cycle request to transmit cmd
//            cmd[15:0]    - command word, sampled when snd_cmd is accepted
//            busy         - command transmission in progress
//            cmd_sent     - 1-cycle pulse when the low-byte stop bit ends
//            resp[7:0]    - last good response byte
//            resp_rdy     - resp valid, sticky until cleared
//            clr_resp_rdy - clears resp_rdy
// Modports : master - the user of the link; slave - the link endpoint
// Revision : 1.0 - initial release
// ============================================================================
interface cmd_host_comm_if;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        busy;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;

  modport master (
    output snd_cmd, cmd, clr_resp_rdy,
    input  busy, cmd_sent, resp, resp_rdy
  );

  modport slave (
    input  snd_cmd, cmd, clr_resp_rdy,
    output busy, cmd_sent, resp, resp_rdy
  );
endinterface
`default_nettype wire

// File: rtl/cmd_host_comm.sv
`default_nettype none
// ============================================================================
// Module   : cmd_host_comm
// Purpose  : Host-side end of a 2-byte-command / 1-byte-response serial link.
//            Sends a 16-bit command as two 8N1 frames (high byte first) on
//            TX and receives 8-bit response frames on RX. Serializer and
//            deserializer are built in; TX and RX run independently.
// Ports    : clk          - clock
//            rst_n        - asynchronous active-low reset
//            host         - command/response handshake (slave modport)
//            TX           - serial out, idles high
//            RX           - serial in, asynchronous to clk
//            resp_timeout - 1-cycle pulse when no response arrives in time
//                           (present only with RESP_TIMEOUT_EN)
// Config   : `define RESP_TIMEOUT_EN to build the response timeout counter
//            and the resp_timeout port.
// Params   : BAUD_DIV    - clk cycles per bit (>= 4)
//            TIMEOUT_CYC - cycles from cmd_sent to timeout pulse
// Revision : 1.0 - initial release
// ============================================================================
module cmd_host_comm #(
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 1 << 20
) (
  input  logic              clk,
  input  logic              rst_n,
  cmd_host_comm_if.slave    host,
  output logic              TX,
  input  logic              RX
`ifdef RESP_TIMEOUT_EN
  ,
  output logic              resp_timeout
`endif
);

  localparam int            BW         = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST  = BW'(BAUD_DIV / 2 - 1);

  // --------------------------------------------------------------------------
  // TX path
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HIGH = 2'd1,
    TX_LOW  = 2'd2
  } tx_state_e;

  tx_state_e     tx_state_q;
  logic [15:0]   cmd_q;
  logic [3:0]    tx_bit_q;
  logic [BW-1:0] tx_cnt_q;
  logic          tx_q;
  logic          busy_q;
  logic          cmd_sent_q;
  logic          tx_accept;
  logic [7:0]    tx_byte;
  logic [3:0]    tx_bit_nxt;

  // Line level for bit position idx of a frame: 0 start, 1..8 data, 9 stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic [3:0] k;
    k = idx - 4'd1;
    if (idx == 4'd0)      return 1'b0;
    else if (idx >= 4'd9) return 1'b1;
    else                  return b[k[2:0]];
  endfunction

  // A request coinciding with the cmd_sent pulse is dropped, not queued.
  assign tx_accept  = (tx_state_q == TX_IDLE) && host.snd_cmd && !cmd_sent_q;
  assign tx_byte    = (tx_state_q == TX_HIGH) ? cmd_q[15:8] : cmd_q[7:0];
  assign tx_bit_nxt = tx_bit_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      cmd_q      <= 16'h0000;
      tx_bit_q   <= 4'd0;
      tx_cnt_q   <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      cmd_sent_q <= 1'b0;
    end else begin
      cmd_sent_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_accept) begin
            cmd_q      <= host.cmd;
            tx_state_q <= TX_HIGH;
            busy_q     <= 1'b1;
            tx_bit_q   <= 4'd0;
            tx_cnt_q   <= BAUD_LAST;
            tx_q       <= 1'b0;
          end
        end
        TX_HIGH, TX_LOW: begin
          if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
          end else begin
            tx_cnt_q <= BAUD_LAST;
            if (tx_bit_q == 4'd9) begin
              tx_bit_q <= 4'd0;
              if (tx_state_q == TX_HIGH) begin
                // Low-byte start bit follows the high-byte stop bit directly.
                tx_state_q <= TX_LOW;
                tx_q       <= 1'b0;
              end else begin
                tx_state_q <= TX_IDLE;
                busy_q     <= 1'b0;
                cmd_sent_q <= 1'b1;
                tx_q       <= 1'b1;
              end
            end else begin
              tx_bit_q <= tx_bit_nxt;
              tx_q     <= frame_bit(tx_byte, tx_bit_nxt);
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign TX            = tx_q;
  assign host.busy     = busy_q;
  assign host.cmd_sent = cmd_sent_q;

  // --------------------------------------------------------------------------
  // RX path
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  logic          rx_meta_q;
  logic          rx_sync_q;
  logic          rx_prev_q;
  rx_state_e     rx_state_q;
  logic [BW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    resp_q;
  logic          resp_rdy_q;
  logic          rx_good;

  // Synchronizer and edge-detect history preset to the idle line level so
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_good = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && rx_sync_q;

  // A framing error returns to IDLE; since IDLE needs a 1->0 transition, a
  // line held low is ignored until it has gone high again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else if (rx_sync_q) begin
            rx_state_q <= RX_IDLE;
          end else begin
            rx_state_q <= RX_DATA;
            rx_cnt_q   <= BAUD_LAST;
            rx_bit_q   <= 3'd0;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else begin
            rx_cnt_q   <= BAUD_LAST;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != '0) rx_cnt_q   <= rx_cnt_q - 1'b1;
          else                rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase

      if (rx_good) resp_q <= rx_shift_q;

      // A fresh byte outranks a clear in the same cycle.
      if (rx_good)                                resp_rdy_q <= 1'b1;
      else if (host.clr_resp_rdy || tx_accept)    resp_rdy_q <= 1'b0;
    end
  end

  assign host.resp     = resp_q;
  assign host.resp_rdy = resp_rdy_q;

  // --------------------------------------------------------------------------
  // Response timeout
  // --------------------------------------------------------------------------
`ifdef RESP_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] to_cnt_q;
  logic          to_run_q;
  logic          resp_timeout_q;

  // Counter holds the number of cycles elapsed since cmd_sent, so the pulse
  // lands exactly TIMEOUT_CYC cycles after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q       <= '0;
      to_run_q       <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      resp_timeout_q <= 1'b0;
      if (cmd_sent_q) begin
        to_run_q <= 1'b1;
        to_cnt_q <= TW'(1);
      end else if (to_run_q) begin
        if (rx_good || tx_accept) begin
          to_run_q <= 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          to_run_q       <= 1'b0;
          resp_timeout_q <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end
    end
  end

  assign resp_timeout = resp_timeout_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmd_host_comm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_host_comm
// Purpose  : Directed self-checking bench for cmd_host_comm with BAUD_DIV=8
//            and TIMEOUT_CYC=500. Timeout checks are built only when
//            RESP_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_host_comm;

  localparam int BD = 8;

  logic clk;
  logic rst_n;
  logic RX;
  wire  TX;
`ifdef RESP_TIMEOUT_EN
  wire  resp_timeout;
`endif

  int n_total = 0;
  int n_bad   = 0;

  cmd_host_comm_if hif ();

  cmd_host_comm #(
    .BAUD_DIV    (BD),
    .TIMEOUT_CYC (500)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (hif),
    .TX           (TX),
    .RX           (RX)
`ifdef RESP_TIMEOUT_EN
    ,
    .resp_timeout (resp_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RESP_TIMEOUT_EN
  int to_seen = 0;
  always @(posedge clk) if (resp_timeout) to_seen <= to_seen + 1;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts a command and decodes the wire mid-bit. Returns just after the
  // edge on which cmd_sent should be high (160 clks after TX falls).
  task automatic tx_send(input logic [15:0] c, input bit mid_snd);
    logic [19:0] bits;
    int          early;
    bits  = '0;
    early = 0;
    hif.snd_cmd = 1'b1;
    hif.cmd     = c;
    @(posedge clk); #1;
    hif.snd_cmd = 1'b0;
    chk("tx_fall", TX, 1'b0);
    chk("busy_on", hif.busy, 1'b1);
    for (int t = 1; t <= 20 * BD; t++) begin
      if (mid_snd && t == 40) begin hif.snd_cmd = 1'b1; hif.cmd = 16'hFFFF; end
      if (mid_snd && t == 41) hif.snd_cmd = 1'b0;
      @(posedge clk); #1;
      if (t % BD == BD / 2) bits[t / BD] = TX;
      if (t < 20 * BD && (hif.cmd_sent || !hif.busy)) early++;
    end
    chk("tx_hi",    bits[8:1],   c[15:8]);
    chk("tx_lo",    bits[18:11], c[7:0]);
    chk("tx_frm",   {bits[19], bits[10], bits[9], bits[0]}, 4'b1010);
    chk("tx_early", early, 0);
    chk("cmd_sent", hif.cmd_sent, 1'b1);
    chk("busy_off", hif.busy, 1'b0);
    chk("tx_idle",  TX, 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    RX = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int lows;
`ifdef RESP_TIMEOUT_EN
    int first;
    int base;
`endif
    rst_n            = 1'b0;
    RX               = 1'b1;
    hif.snd_cmd      = 1'b0;
    hif.cmd          = 16'h0000;
    hif.clr_resp_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_tx",       TX, 1'b1);
    chk("rst_busy",     hif.busy, 1'b0);
    chk("rst_cmd_sent", hif.cmd_sent, 1'b0);
    chk("rst_resp",     hif.resp, 8'h00);
    chk("rst_resp_rdy", hif.resp_rdy, 1'b0);
`ifdef RESP_TIMEOUT_EN
    chk("rst_timeout",  resp_timeout, 1'b0);
`endif

    // Command A53C with an ignored FFFF request in the middle
    tx_send(16'hA53C, 1'b1);

    // Request in the cmd_sent cycle is dropped
    hif.snd_cmd = 1'b1;
    hif.cmd     = 16'h1234;
    @(posedge clk); #1;
    hif.snd_cmd = 1'b0;
    chk("same_cyc_pulse", hif.cmd_sent, 1'b0);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (!TX || hif.busy) lows++;
      @(posedge clk); #1;
    end
    chk("same_cyc_ignored", lows, 0);

    // Good response, then clear
    send_rx(8'h5A, 1'b1);
    chk("rx_resp", hif.resp, 8'h5A);
    chk("rx_rdy",  hif.resp_rdy, 1'b1);
    hif.clr_resp_rdy = 1'b1;
    @(posedge clk); #1;
    hif.clr_resp_rdy = 1'b0;
    chk("clr_rdy",  hif.resp_rdy, 1'b0);
    chk("clr_hold", hif.resp, 8'h5A);

    // Framing error is discarded
    send_rx(8'hC3, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk("ferr_resp", hif.resp, 8'h5A);
    chk("ferr_rdy",  hif.resp_rdy, 1'b0);

    // Short low glitch is not a frame
    RX = 1'b0;
    repeat (2) @(posedge clk);
    #1 RX = 1'b1;
    repeat (100) @(posedge clk); #1;
    chk("glitch_rdy",  hif.resp_rdy, 1'b0);
    chk("glitch_resp", hif.resp, 8'h5A);

    // Recovery, then overrun keeps resp_rdy and takes the new byte
    send_rx(8'h81, 1'b1);
    chk("rx2_resp", hif.resp, 8'h81);
    chk("rx2_rdy",  hif.resp_rdy, 1'b1);
    send_rx(8'h7E, 1'b1);
    chk("ovr_resp", hif.resp, 8'h7E);
    chk("ovr_rdy",  hif.resp_rdy, 1'b1);

    // Accepted command clears resp_rdy; reset mid high byte
    hif.snd_cmd = 1'b1;
    hif.cmd     = 16'hC0DE;
    @(posedge clk); #1;
    hif.snd_cmd = 1'b0;
    chk("snd_clr_rdy", hif.resp_rdy, 1'b0);
    chk("snd2_tx",     TX, 1'b0);
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx",   TX, 1'b1);
    chk("midrst_busy", hif.busy, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_tx", TX, 1'b1);
    tx_send(16'h0F81, 1'b0);

`ifdef RESP_TIMEOUT_EN
    // No response: pulse exactly 500 clks after cmd_sent
    first = 0;
    for (int k = 1; k <= 700; k++) begin
      @(posedge clk); #1;
      if (resp_timeout && first == 0) first = k;
    end
    chk("to_at", first, 500);

    // Response at +200: no pulse
    tx_send(16'h2468, 1'b0);
    base = to_seen;
    repeat (199) @(posedge clk);
    #1;
    send_rx(8'h11, 1'b1);
    repeat (450) @(posedge clk); #1;
    chk("to_resp",   hif.resp, 8'h11);
    chk("to_none",   to_seen - base, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
